dpll_nco: RTL and testbench

DPLL_NCO -- requirements
Module: dpll_nco

---
 rtl/dpll_nco.sv | 175 +++++++++++++++++
 tb/tb_dpll_nco.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpll_nco.sv
// Digital PLL: measures the clk_in period in clk_ref cycles and regenerates clk_out and a
// MULT-times clk_out_mx from a fractional NCO. Define DPLL_HOLDOVER_EN to keep the NCO running on input loss.
module dpll_nco #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MULT_LOG2 = 3,
    parameter int unsigned LOCK_TOL  = 2,
    parameter int unsigned LOCK_CNT  = 4
) (
    input  logic             clk_ref,
    input  logic             rst,
    input  logic             clk_in,
    output logic             clk_out,
    output logic             clk_out_mx,
    output logic             locked,
    output logic [CNT_W-1:0] period
);

    localparam int unsigned AccW = CNT_W + 1;
    localparam int unsigned StW  = $clog2(LOCK_CNT + 1);
    localparam logic [AccW-1:0]  Step   = AccW'(2 ** (MULT_LOG2 + 1));
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [StW-1:0]   StMax  = StW'(LOCK_CNT);

    typedef enum logic [0:0] {StAcq, StLock} state_e;

    logic                 sync1_q, sync2_q, prev_q, edge_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     per_q, per_d;
    logic                 seen_q, seen_d;
    logic                 valid_q, valid_d;
    logic                 loss_q, loss_d;
    logic [AccW-1:0]      acc_q, acc_d;
    logic [MULT_LOG2-1:0] tog_q, tog_d;
    logic                 mx_q, mx_d;
    logic                 out_q, out_d;
    logic [StW-1:0]       stable_q, stable_d;
    state_e               state_q, state_d;

    logic                 cnt_sat, loss_evt, measure, stable_ok;
    logic [CNT_W-1:0]     meas;
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]       mag;
    logic [AccW-1:0]      acc_step;

    always_comb begin
        cnt_sat   = (cnt_q == CntMax);
        loss_evt  = cnt_sat & ~edge_q;
        meas      = cnt_sat ? CntMax : cnt_q + CNT_W'(1);
        measure   = edge_q & seen_q;
        diff      = $signed({1'b0, meas}) - $signed({1'b0, per_q});
        mag       = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
        stable_ok = valid_q & (mag <= AccW'(LOCK_TOL));
        acc_step  = acc_q + Step;
    end

    // Period measurement and input-loss tracking; an edge always wins over saturation.
    always_comb begin
        cnt_d   = edge_q ? '0 : (cnt_sat ? cnt_q : cnt_q + CNT_W'(1));
        loss_d  = edge_q ? 1'b0 : (loss_q | cnt_sat);
        seen_d  = seen_q;
        per_d   = per_q;
        valid_d = valid_q;
        if (edge_q) begin
            seen_d = 1'b1;
            if (seen_q) begin
                per_d   = meas;
                valid_d = 1'b1;
            end
        end else if (cnt_sat) begin
            // The edge after a loss only restarts the count; it is never measured.
            seen_d = 1'b0;
`ifdef DPLL_HOLDOVER_EN
            valid_d = valid_q;
`else
            valid_d = 1'b0;
`endif
        end
    end

    always_comb begin
        acc_d = acc_q;
        tog_d = tog_q;
        mx_d  = mx_q;
        out_d = out_q;
        if (!(valid_q && valid_d)) begin
            acc_d = '0;
            tog_d = '0;
            mx_d  = 1'b0;
            out_d = 1'b0;
        end else if (edge_q && (state_q == StLock)) begin
            acc_d = '0;
            tog_d = '0;
            mx_d  = 1'b1;
            out_d = 1'b1;
        end else if (acc_step >= {1'b0, per_q}) begin
            acc_d = acc_step - {1'b0, per_q};
            mx_d  = ~mx_q;
            tog_d = tog_q + MULT_LOG2'(1);
            if (tog_q == '1) begin
                out_d = ~out_q;
            end
        end else begin
            acc_d = acc_step;
        end
    end

    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        unique case (state_q)
            StAcq: begin
                if (measure) begin
                    if (stable_ok) begin
                        stable_d = stable_q + StW'(1);
                        if (stable_d == StMax) begin
                            state_d = StLock;
                        end
                    end else begin
                        stable_d = '0;
                    end
                end else if (loss_evt) begin
                    stable_d = '0;
                end
            end
            StLock: begin
                if ((measure && !stable_ok) || loss_evt) begin
                    state_d  = StAcq;
                    stable_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_ref) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            edge_q   <= 1'b0;
            cnt_q    <= '0;
            per_q    <= '0;
            seen_q   <= 1'b0;
            valid_q  <= 1'b0;
            loss_q   <= 1'b0;
            acc_q    <= '0;
            tog_q    <= '0;
            mx_q     <= 1'b0;
            out_q    <= 1'b0;
            stable_q <= '0;
            state_q  <= StAcq;
        end else begin
            sync1_q  <= clk_in;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            edge_q   <= sync2_q & ~prev_q;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            seen_q   <= seen_d;
            valid_q  <= valid_d;
            loss_q   <= loss_d;
            acc_q    <= acc_d;
            tog_q    <= tog_d;
            mx_q     <= mx_d;
            out_q    <= out_d;
            stable_q <= stable_d;
            state_q  <= state_d;
        end
    end

    assign clk_out    = out_q;
    assign clk_out_mx = mx_q;
    assign locked     = (state_q == StLock);
    assign period     = per_q;

endmodule

// File: tb/tb_dpll_nco.sv
// Randomised bench for dpll_nco: a cycle-level behavioural model is compared with the DUT
// outputs on every falling clk_ref edge, plus hand-derived checks of lock, period and waveforms.
module tb_dpll_nco;

    localparam int CntW     = 16;
    localparam int MultLog2 = 3;
    localparam int Mult     = 8;
    localparam int LockTol  = 2;
    localparam int LockCnt  = 4;
    localparam int MaxC     = 65535;

    logic            clk_ref = 1'b0;
    logic            rst;
    logic            clk_in;
    logic            clk_out, clk_out_mx, locked;
    logic [CntW-1:0] period;

    int n_checks = 0;
    int n_fail   = 0;

    dpll_nco #(
        .CNT_W    (CntW),
        .MULT_LOG2(MultLog2),
        .LOCK_TOL (LockTol),
        .LOCK_CNT (LockCnt)
    ) dut (
        .clk_ref   (clk_ref),
        .rst       (rst),
        .clk_in    (clk_in),
        .clk_out   (clk_out),
        .clk_out_mx(clk_out_mx),
        .locked    (locked),
        .period    (period)
    );

    always #5 clk_ref = ~clk_ref;

    // Behavioural model state
    bit [4:0] hist;
    int       since, per, stable, acc, tcnt;
    bit       seen, valid, m_locked, base;

    task automatic model_step();
        bit edge_now, ov, ol, ok;
        int op, meas, d;
        if (!rst) begin
            hist = '0; since = 0; seen = 0; valid = 0; per = 0;
            m_locked = 0; stable = 0; acc = 0; tcnt = 0; base = 0;
            return;
        end
        hist     = {hist[3:0], clk_in};
        edge_now = hist[3] & ~hist[4];
        ov = valid; ol = m_locked; op = per;
        if (edge_now) begin
            if (seen) begin
                meas = (since + 1 > MaxC) ? MaxC : since + 1;
                d    = meas - op;
                if (d < 0) d = -d;
                ok   = ov && (d <= LockTol);
                per  = meas;
                valid = 1;
                if (!m_locked) begin
                    stable = ok ? stable + 1 : 0;
                    if (stable == LockCnt) m_locked = 1;
                end else if (!ok) begin
                    m_locked = 0;
                    stable   = 0;
                end
            end
            seen  = 1;
            since = 0;
        end else begin
            since++;
            if (since == MaxC + 1) begin
                seen = 0; m_locked = 0; stable = 0;
`ifndef DPLL_HOLDOVER_EN
                valid = 0;
`endif
            end
        end
        if (!(ov && valid)) begin
            acc = 0; tcnt = 0; base = 0;
        end else if (edge_now && ol) begin
            acc = 0; tcnt = 0; base = 1;
        end else begin
            acc += 2 * Mult;
            if (acc >= op) begin
                acc -= op;
                tcnt = (tcnt + 1) % (2 * Mult);
            end
        end
    endtask

    initial forever begin
        @(posedge clk_ref);
        model_step();
    end

    initial forever begin
        bit e_mx, e_out;
        @(negedge clk_ref);
        e_mx  = base ^ tcnt[0];
        e_out = base ^ tcnt[MultLog2];
        n_checks++;
        if (clk_out_mx !== e_mx || clk_out !== e_out || locked !== m_locked ||
            period !== CntW'(per)) begin
            n_fail++;
            $display("FAIL cycle_compare t=%0t: out=%b/%b mx=%b/%b locked=%b/%b period=%0d/%0d (got/required)",
                     $time, clk_out, e_out, clk_out_mx, e_mx, locked, m_locked, period, per);
        end
    end

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic run_cyc(input int n);
        repeat (n) @(posedge clk_ref);
        #2;
    endtask

    task automatic pulse(input int hi, input int lo);
        clk_in = 1'b1;
        run_cyc(hi);
        clk_in = 1'b0;
        run_cyc(lo);
    endtask

    // Length of the first complete high run and following low run of clk_out (which=1) or clk_out_mx.
    task automatic measure_runs(input bit which, output int hi, output int lo);
        bit prev, cur;
        int n;
        hi = -1;
        lo = -1;
        @(negedge clk_ref);
        prev = which ? clk_out : clk_out_mx;
        cur  = prev;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk_ref);
            cur = which ? clk_out : clk_out_mx;
            if (cur && !prev) break;
            prev = cur;
        end
        if (n >= 2000) return;
        hi = 0;
        while (cur && hi < 2000) begin
            hi++;
            @(negedge clk_ref);
            cur = which ? clk_out : clk_out_mx;
        end
        lo = 0;
        while (!cur && lo < 2000) begin
            lo++;
            @(negedge clk_ref);
            cur = which ? clk_out : clk_out_mx;
        end
    endtask

    int hi_len, lo_len;

    initial begin
        rst    = 1'b0;
        clk_in = 1'b0;
        run_cyc(4);
        check("reset_clk_out", clk_out, 0);
        check("reset_clk_out_mx", clk_out_mx, 0);
        check("reset_locked", locked, 0);
        check("reset_period", period, 0);
        rst = 1'b1;

        // 512-cycle input: lock at the 6th detected edge
        repeat (5) pulse(256, 256);
        clk_in = 1'b1;
        run_cyc(2);
        check("locked_before_edge6", locked, 0);
        run_cyc(3);
        check("locked_at_edge6", locked, 1);
        check("model_locked_at_edge6", m_locked, 1);
        check("period_512", period, 512);
        check("model_period_512", per, 512);
        run_cyc(251);
        clk_in = 1'b0;
        run_cyc(256);
        fork
            pulse(256, 256);
            measure_runs(1'b0, hi_len, lo_len);
        join
        check("mx_high_32", hi_len, 32);
        check("mx_low_32", lo_len, 32);
        fork
            begin pulse(256, 256); pulse(256, 256); end
            measure_runs(1'b1, hi_len, lo_len);
        join
        check("clk_out_period_512", hi_len + lo_len, 512);

        // 511-cycle input stays locked
        repeat (4) pulse(255, 256);
        check("locked_511", locked, 1);
        check("period_511_or_512", (period == 511 || period == 512), 1);

        // Step to 600: unlock at the first 600 edge, relock four stable edges later
        pulse(300, 300);
        clk_in = 1'b1;
        run_cyc(5);
        check("unlock_first_600", locked, 0);
        check("period_600_first", period, 600);
        run_cyc(295);
        clk_in = 1'b0;
        run_cyc(300);
        repeat (4) pulse(300, 300);
        check("relock_600", locked, 1);
        check("period_600", period, 600);

        // Jitter around the lock tolerance, then fully random periods
        repeat (8) pulse(300, 300 + $urandom_range(0, 3));
        repeat (4) pulse($urandom_range(200, 320), $urandom_range(200, 320));
        repeat (6) pulse(256, 256);
        check("relock_512", locked, 1);

        // One-cycle reset mid-lock
        clk_in = 1'b1;
        run_cyc(100);
        clk_in = 1'b0;
        rst    = 1'b0;
        run_cyc(1);
        check("midreset_clk_out", clk_out, 0);
        check("midreset_clk_out_mx", clk_out_mx, 0);
        check("midreset_locked", locked, 0);
        check("midreset_period", period, 0);
        rst = 1'b1;
        run_cyc(400);
        pulse(256, 256);
        clk_in = 1'b1;
        run_cyc(2);
        check("period_before_edge2", period, 0);
        run_cyc(3);
        check("period_at_edge2", period, 512);
        run_cyc(251);
        clk_in = 1'b0;
        run_cyc(256);
        repeat (4) pulse(256, 256);
        check("locked_after_reset", locked, 1);

        // Stop clk_in: loss after the count saturates
        run_cyc(64900);
        check("locked_before_loss", locked, 1);
        run_cyc(700);
        check("locked_after_loss", locked, 0);
`ifdef DPLL_HOLDOVER_EN
        measure_runs(1'b0, hi_len, lo_len);
        check("holdover_mx_period_64", hi_len + lo_len, 64);
        measure_runs(1'b1, hi_len, lo_len);
        check("holdover_out_period_512", hi_len + lo_len, 512);
`else
        check("loss_clk_out", clk_out, 0);
        check("loss_clk_out_mx", clk_out_mx, 0);
`endif
        repeat (2) pulse(256, 256);
        check("period_after_resume", period, 512);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
